// File: rtl/quant_sched_if.sv
// Handshake and configuration bundle between a quant_sched block and its neighbours.
// The slave modport is the quantizer side; master is the psum source / writeback / config side.
interface quant_sched_if #(
    parameter int ACC_WIDTH = 32,
    parameter int M0_WIDTH  = 32,
    parameter int LANES     = 4
);
    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                       cfg_we;
    logic [IDXW-1:0]            cfg_addr;
    logic [M0_WIDTH-1:0]        cfg_m0;
    logic                       cfg_drop;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*ACC_WIDTH-1:0] in_psum;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*8-1:0]         out_data;
    logic                       busy;

    modport slave (
        input  cfg_we, cfg_addr, cfg_m0, in_valid, in_psum, out_ready,
        output cfg_drop, in_ready, out_valid, out_data, busy
    );

    modport master (
        output cfg_we, cfg_addr, cfg_m0, in_valid, in_psum, out_ready,
        input  cfg_drop, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/quant_sched.sv
// Time-multiplexes one requantizer (x M0, round half-up, >>> FIXED_SHIFT, saturate to int8)
// across the lanes of a systolic-array row, with a per-lane M0 table.
//
//   state   | meaning
//   S_IDLE  | in_ready high, waiting for a psum vector; scale table writable
//   S_QUANT | one lane quantized per cycle, LANES cycles total
//   S_OUT   | packed int8 vector presented, waiting for out_ready
module quant_sched #(
    parameter int ACC_WIDTH   = 32,
    parameter int M0_WIDTH    = 32,
    parameter int FIXED_SHIFT = 16,
    parameter int LANES       = 4
) (
    input  logic          clk,
    input  logic          rst,
    quant_sched_if.slave  bus
);
    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW   = ACC_WIDTH + M0_WIDTH + 1;

    localparam logic [IDXW-1:0]            LAST    = IDXW'(LANES - 1);
    localparam logic [IDXW:0]              LANES_W = (IDXW + 1)'(LANES);
    localparam logic signed [M0_WIDTH-1:0] UNITY   = M0_WIDTH'(1) << FIXED_SHIFT;
    localparam logic signed [PW-1:0]       RND     = PW'(1) << (FIXED_SHIFT - 1);
    localparam logic signed [PW-1:0]       SAT_HI  = PW'(127);
    localparam logic signed [PW-1:0]       SAT_LO  = PW'(-128);

    typedef enum logic [1:0] {S_IDLE, S_QUANT, S_OUT} state_t;

    state_t                       r_state;
    logic [IDXW-1:0]              r_cnt;
    logic signed [ACC_WIDTH-1:0]  r_buf [LANES];
    logic signed [M0_WIDTH-1:0]   r_m0  [LANES];
    logic [7:0]                   r_q   [LANES];
    logic                         r_out_valid;
    logic                         r_in_ready;
    logic                         r_busy;
    logic                         r_cfg_drop;

    logic signed [ACC_WIDTH-1:0]  w_p;
    logic signed [M0_WIDTH-1:0]   w_m;
    logic signed [PW-1:0]         w_pe;
    logic signed [PW-1:0]         w_me;
    logic signed [PW-1:0]         w_prod;
    logic signed [PW-1:0]         w_r;
    logic signed [PW-1:0]         w_s;
    logic [7:0]                   w_q;
    logic                         w_cfg_ok;

    // One extra bit of headroom so the rounding add can never wrap.
    always_comb begin
        w_p    = r_buf[r_cnt];
        w_m    = r_m0[r_cnt];
        w_pe   = PW'(w_p);
        w_me   = PW'(w_m);
        w_prod = w_pe * w_me;
        w_r    = w_prod + RND;
        w_s    = w_r >>> FIXED_SHIFT;
        if (w_s > SAT_HI)
            w_q = 8'h7F;
        else if (w_s < SAT_LO)
            w_q = 8'h80;
        else
            w_q = w_s[7:0];
    end

    assign w_cfg_ok = bus.cfg_we && (r_state == S_IDLE) && ({1'b0, bus.cfg_addr} < LANES_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_cfg_drop  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_buf[i] <= '0;
                r_m0[i]  <= UNITY;
                r_q[i]   <= '0;
            end
        end else begin
            r_cfg_drop <= bus.cfg_we && !w_cfg_ok;
            if (w_cfg_ok)
                r_m0[bus.cfg_addr] <= bus.cfg_m0;

            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        for (int i = 0; i < LANES; i++)
                            r_buf[i] <= bus.in_psum[i*ACC_WIDTH +: ACC_WIDTH];
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_QUANT;
                    end
                end
                S_QUANT: begin
                    r_q[r_cnt] <= w_q;
                    if (r_cnt == LAST) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign bus.out_data[g*8 +: 8] = r_q[g];
    end

    assign bus.out_valid = r_out_valid;
    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.cfg_drop  = r_cfg_drop;
endmodule

// File: doc/quant_sched.md
Name: quant_sched

Overview:
- Sequences one shared quantizer datapath (multiply by per-channel M0, round half-up, arithmetic shift by FIXED_SHIFT, saturate to int8) across the LANES accumulator outputs of one systolic-array row.
- Holds the per-lane M0 scale table, which is configured through a write port.
- Accepts a psum vector with a valid/ready handshake, quantizes one lane per cycle, and presents a packed int8 vector to the activation/writeback path, also valid/ready.

Parameters:
- ACC_WIDTH, 32, signed psum width.
- M0_WIDTH, 32, signed fixed-point scale width (Q.FIXED_SHIFT).
- FIXED_SHIFT, 16, right shift applied after the multiply.
- LANES, 4, lanes per vector (>=2); IDXW = max(1, $clog2(LANES)).

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- cfg_we, in, 1, scale-table write strobe.
- cfg_addr, in, IDXW, lane index to write.
- cfg_m0, in, M0_WIDTH, signed scale value.
- cfg_drop, out, 1, one-cycle pulse: a write was rejected.
- in_valid, in, 1, psum vector valid.
- in_ready, out, 1, block can accept a vector.
- in_psum, in, LANES*ACC_WIDTH, lane i in bits [i*ACC_WIDTH +: ACC_WIDTH], signed.
- out_valid, out, 1, quantized vector valid.
- out_ready, in, 1, downstream accepts.
- out_data, out, LANES*8, lane i in bits [8i +: 8], signed int8.
- busy, out, 1, high in QUANT or OUT.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; lane counter=0; input buffer and out_data=0.
  - out_valid=0, cfg_drop=0, busy=0; in_ready=1 once in IDLE.
  - Every scale entry = 1<<FIXED_SHIFT (unity scale).
  - An in-flight vector is discarded, with no partial output.
- FSM, IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: capture in_psum into the buffer, lane counter=0, go to QUANT.
- FSM, QUANT:
  - in_ready=0, busy=1.
  - Each edge: out_data lane[cnt] <= quant(buf[cnt], m0[cnt]); cnt++.
  - After the edge that writes lane LANES-1, go to OUT.
  - QUANT lasts exactly LANES cycles.
- FSM, OUT:
  - out_valid=1, busy=1, in_ready=0.
  - out_data is held stable while out_valid && !out_ready.
  - On out_valid&&out_ready at an edge: out_valid<=0, go to IDLE.
- Latency and throughput:
  - out_valid rises LANES edges after the accepting edge (4 for the defaults).
  - Minimum accept-to-accept period is LANES+2 cycles (6 for the defaults).
  - in_ready is never high while a vector is held, so there is no overlap.
- quant(p, m), combinational on the registered operands:
  - prod = p*m, full-width signed, ACC_WIDTH+M0_WIDTH bits.
  - r = prod + (1<<(FIXED_SHIFT-1)); s = r >>> FIXED_SHIFT.
  - If s>127 the result is 127; if s<-128 it is -128; otherwise s[7:0].
  - Rounding is half toward +inf.
- Config:
  - When cfg_we=1 in IDLE and cfg_addr<LANES: m0[cfg_addr] <= cfg_m0 at the edge.
  - The new value is used by any vector accepted at a later edge.
  - A write in the same cycle as an accept takes effect for that vector, because lanes are quantized on later edges.
  - When cfg_we=1 in QUANT or OUT, or cfg_addr>=LANES: the write is ignored, the table is unchanged, and cfg_drop pulses high for the next cycle.
  - A write and an accept in the same IDLE cycle are both performed.
- Other boundaries:
  - in_valid while busy: ignored, with no state change; the source must hold it.
  - out_ready high outside OUT: no effect.
  - The lane counter never exceeds LANES-1 and resets to 0 on each accept.

Test Plan:
1. Reset, then accept psums {5,-3,200,-300} at unity scale -> out_valid exactly 4 edges later, out_data lanes {5,-3,127,-128}; busy high through the handshake.
2. In IDLE write m0[0]=0x8000 and m0[1]=0x8000 (0.5), then send {3,-3,1,0} -> lanes {2,-1,1,0}, exercising round half-up.
3. Hold out_ready=0 for 10 cycles after out_valid with in_valid=1 -> out_data stable, in_ready=0, no second accept; raise out_ready -> IDLE, then the next vector is accepted.
4. cfg_we during QUANT (addr 0, value 0), and in IDLE with cfg_addr=LANES (non-power-of-2 build, LANES=3) -> cfg_drop pulses once each; the next vector still uses the old scales.
5. Assert rst for 1 cycle mid-QUANT after a non-unity config -> outputs 0 immediately; the next vector {7,...} returns 7 (unity restored), with no stale output.
6. in_valid and out_ready tied high, 5 vectors streamed -> accepts spaced exactly 6 cycles apart, outputs in order, each matching a reference model.
